// File: rtl/snoop_ac_queue.sv
// snoop_ac_queue: ingress buffer for ACE snoop requests (AC channel).
// Requests are queued in a DEPTH-entry FIFO. The head is offered downstream
// with AXI-stable valid/ready semantics. An unpresented head is held back
// while the miss handler flushes or an AMO targets the same cache line.
// A watchdog pulses stall_o once when the head has been blocked STALL_LIMIT
// consecutive cycles.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   ac_valid_i/ac_ready_o             upstream handshake
//   ac_addr_i/ac_snoop_i/ac_prot_i    upstream payload
//   out_valid_o/out_ready_i           downstream handshake
//   out_addr_o/out_snoop_o/out_prot_o head payload (don't-care when empty)
//   flushing_i, amo_valid_i, amo_addr_i  hold-back sources
//   count_o                           occupancy
//   stall_o                           one-cycle blocked-head pulse
module snoop_ac_queue #(
  parameter int DEPTH       = 4,
  parameter int LINE_OFFSET = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ac_valid_i,
  output logic                     ac_ready_o,
  input  logic [63:0]              ac_addr_i,
  input  logic [3:0]               ac_snoop_i,
  input  logic [2:0]               ac_prot_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              out_addr_o,
  output logic [3:0]               out_snoop_o,
  output logic [2:0]               out_prot_o,
  input  logic                     flushing_i,
  input  logic                     amo_valid_i,
  input  logic [63:0]              amo_addr_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     stall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   addr_mem_q  [DEPTH];
  logic [63:0]   addr_mem_d  [DEPTH];
  logic [3:0]    snoop_mem_q [DEPTH];
  logic [3:0]    snoop_mem_d [DEPTH];
  logic [2:0]    prot_mem_q  [DEPTH];
  logic [2:0]    prot_mem_d  [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pres_q, pres_d;
  logic [7:0]    stall_cnt_q, stall_cnt_d;

  logic          push, pop, block, not_empty, head_blocked;

  // Only the line address of the AMO participates in the conflict check.
  logic unused_amo_offset;
  assign unused_amo_offset = ^amo_addr_i[LINE_OFFSET-1:0];

  assign not_empty   = (cnt_q != '0);
  assign ac_ready_o  = (cnt_q != CW'(DEPTH));
  assign out_addr_o  = addr_mem_q[rptr_q];
  assign out_snoop_o = snoop_mem_q[rptr_q];
  assign out_prot_o  = prot_mem_q[rptr_q];
  assign count_o     = cnt_q;

  assign block = flushing_i ||
                 (amo_valid_i && (amo_addr_i[63:LINE_OFFSET] == out_addr_o[63:LINE_OFFSET]));

  // Once presented (pres_q), the head stays valid regardless of block.
  assign out_valid_o  = not_empty && (pres_q || !block);
  assign head_blocked = not_empty && !out_valid_o;

  assign push = ac_valid_i && ac_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Pulse in the cycle whose edge brings the counter to STALL_LIMIT; the
  // counter then saturates, so the pulse cannot repeat without a reset.
  assign stall_o = head_blocked && (stall_cnt_q == 8'(STALL_LIMIT - 1));

  always_comb begin
    addr_mem_d  = addr_mem_q;
    snoop_mem_d = snoop_mem_q;
    prot_mem_d  = prot_mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    pres_d      = pres_q;
    stall_cnt_d = stall_cnt_q;

    if (push) begin
      addr_mem_d[wptr_q]  = ac_addr_i;
      snoop_mem_d[wptr_q] = ac_snoop_i;
      prot_mem_d[wptr_q]  = ac_prot_i;
      wptr_d              = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (pop) begin
      pres_d = 1'b0;
    end else if (out_valid_o) begin
      pres_d = 1'b1;
    end

    if (!head_blocked) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != 8'(STALL_LIMIT)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i]  <= '0;
        snoop_mem_q[i] <= '0;
        prot_mem_q[i]  <= '0;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      pres_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      addr_mem_q  <= addr_mem_d;
      snoop_mem_q <= snoop_mem_d;
      prot_mem_q  <= prot_mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      pres_q      <= pres_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_snoop_ac_queue.sv
module tb_snoop_ac_queue;

  localparam int DEPTH = 4;
  localparam int LOFF  = 4;
  localparam int LIMIT = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ac_valid_i;
  logic        ac_ready_o;
  logic [63:0] ac_addr_i;
  logic [3:0]  ac_snoop_i;
  logic [2:0]  ac_prot_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_addr_o;
  logic [3:0]  out_snoop_o;
  logic [2:0]  out_prot_o;
  logic        flushing_i;
  logic        amo_valid_i;
  logic [63:0] amo_addr_i;
  logic [2:0]  count_o;
  logic        stall_o;

  snoop_ac_queue #(.DEPTH(DEPTH), .LINE_OFFSET(LOFF), .STALL_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o),
    .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_snoop_o(out_snoop_o), .out_prot_o(out_prot_o),
    .flushing_i(flushing_i), .amo_valid_i(amo_valid_i), .amo_addr_i(amo_addr_i),
    .count_o(count_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } req_t;

  typedef struct {
    bit          av;
    logic [63:0] addr;
    logic [3:0]  snoop;
    bit          ordy;
    bit          e_ready;
    bit          e_valid;
    int          e_count;
    logic [63:0] e_addr;
  } vec_t;

  // Reference: FIFO as a queue, a presented flag, and a run length of
  // consecutive blocked cycles.
  req_t m_q[$];
  bit   m_pres;
  int   m_blk;

  int total = 0;
  int bad   = 0;

  bit          last_valid, last_ready, last_stall;
  int          last_count;
  logic [63:0] last_addr;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pres = 0;
    m_blk  = 0;
  endtask

  // Inputs are set by the caller just after a falling edge; outputs are
  // sampled 1 time unit later, the model advances, then we wait for the
  // next falling edge.
  task automatic step();
    int   mcnt;
    bit   blk, ev, es, deq, enq;
    req_t h;
    #1;
    mcnt = m_q.size();
    blk  = 0;
    if (mcnt != 0) begin
      h   = m_q[0];
      blk = flushing_i || (amo_valid_i && ((amo_addr_i >> LOFF) == (h.addr >> LOFF)));
    end
    ev = (mcnt != 0) && (m_pres || !blk);
    es = (mcnt != 0) && !ev && (m_blk + 1 == LIMIT);
    chk("ready", 64'(ac_ready_o), 64'(mcnt != DEPTH));
    chk("valid", 64'(out_valid_o), 64'(ev));
    chk("count", 64'(count_o), 64'(mcnt));
    chk("stall", 64'(stall_o), 64'(es));
    if (ev) begin
      chk("addr", out_addr_o, h.addr);
      chk("snoop", 64'(out_snoop_o), 64'(h.snoop));
      chk("prot", 64'(out_prot_o), 64'(h.prot));
    end
    last_valid = out_valid_o;
    last_ready = ac_ready_o;
    last_stall = stall_o;
    last_count = int'(count_o);
    last_addr  = out_addr_o;
    deq = ev && out_ready_i;
    enq = ac_valid_i && (mcnt != DEPTH);
    if (deq) void'(m_q.pop_front());
    if (enq) m_q.push_back('{ac_addr_i, ac_snoop_i, ac_prot_i});
    if (deq) m_pres = 0;
    else if (ev) m_pres = 1;
    m_blk = ((mcnt != 0) && !ev) ? m_blk + 1 : 0;
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    ac_valid_i  = 0;
    ac_addr_i   = '0;
    ac_snoop_i  = '0;
    ac_prot_i   = '0;
    out_ready_i = 0;
    flushing_i  = 0;
    amo_valid_i = 0;
    amo_addr_i  = '0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready_i = 1;
    for (int i = 0; i < DEPTH + 2; i++) step();
  endtask

  vec_t vecs[16];
  int   pulses, pulse_at;

  initial begin
    idle_inputs();
    rst_ni = 0;
    #1;
    chk("rst_ready", 64'(ac_ready_o), 64'd1);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    model_reset();
    repeat (3) @(negedge clk_i);
    rst_ni = 1;

    // av addr snoop ordy | ready valid count head
    vecs[0]  = '{1, 64'h8000_0040, 4'h8, 1, 1, 0, 0, 64'h0};
    vecs[1]  = '{0, 64'h0,         4'h0, 1, 1, 1, 1, 64'h8000_0040};
    vecs[2]  = '{0, 64'h0,         4'h0, 1, 1, 0, 0, 64'h0};
    vecs[3]  = '{1, 64'hA0,        4'h1, 0, 1, 0, 0, 64'h0};
    vecs[4]  = '{1, 64'hB0,        4'h2, 0, 1, 1, 1, 64'hA0};
    vecs[5]  = '{1, 64'hC0,        4'h3, 0, 1, 1, 2, 64'hA0};
    vecs[6]  = '{1, 64'hD0,        4'h4, 0, 1, 1, 3, 64'hA0};
    vecs[7]  = '{1, 64'hE0,        4'hF, 0, 0, 1, 4, 64'hA0};
    vecs[8]  = '{1, 64'hE0,        4'hF, 0, 0, 1, 4, 64'hA0};
    vecs[9]  = '{1, 64'hE0,        4'hF, 1, 0, 1, 4, 64'hA0};
    vecs[10] = '{1, 64'hE0,        4'hF, 0, 1, 1, 3, 64'hB0};
    vecs[11] = '{0, 64'h0,         4'h0, 1, 0, 1, 4, 64'hB0};
    vecs[12] = '{0, 64'h0,         4'h0, 1, 1, 1, 3, 64'hC0};
    vecs[13] = '{0, 64'h0,         4'h0, 1, 1, 1, 2, 64'hD0};
    vecs[14] = '{0, 64'h0,         4'h0, 1, 1, 1, 1, 64'hE0};
    vecs[15] = '{0, 64'h0,         4'h0, 1, 1, 0, 0, 64'h0};

    for (int i = 0; i < 16; i++) begin
      ac_valid_i  = vecs[i].av;
      ac_addr_i   = vecs[i].addr;
      ac_snoop_i  = vecs[i].snoop;
      ac_prot_i   = 3'(i);
      out_ready_i = vecs[i].ordy;
      step();
      chk($sformatf("vec%0d_ready", i), 64'(last_ready), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d_valid", i), 64'(last_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_count", i), 64'(last_count), 64'(vecs[i].e_count));
      if (vecs[i].e_valid) chk($sformatf("vec%0d_addr", i), last_addr, vecs[i].e_addr);
    end

    // Randomized traffic with frequent same-line AMO collisions.
    for (int i = 0; i < 600; i++) begin
      ac_valid_i  = ($urandom_range(0, 99) < 60);
      ac_addr_i   = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                  : 64'h1000_0000 + 64'($urandom_range(0, 3) << 4) + 64'($urandom_range(0, 15));
      ac_snoop_i  = 4'($urandom);
      ac_prot_i   = 3'($urandom);
      out_ready_i = ($urandom_range(0, 99) < 55);
      flushing_i  = ($urandom_range(0, 99) < 10);
      amo_valid_i = ($urandom_range(0, 99) < 30);
      amo_addr_i  = 64'h1000_0000 + 64'($urandom_range(0, 3) << 4) + 64'($urandom_range(0, 15));
      step();
    end
    drain();

    // Same-line AMO holds the head back; different-line AMO does not.
    idle_inputs();
    ac_valid_i = 1; ac_addr_i = 64'h1000_0010; ac_snoop_i = 4'h9; out_ready_i = 1;
    amo_valid_i = 1; amo_addr_i = 64'h1000_0018;
    step();
    ac_valid_i = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("amo_block", 64'(last_valid), 64'd0);
    end
    amo_valid_i = 0;
    step();
    chk("amo_release", 64'(last_valid), 64'd1);
    ac_valid_i = 1; amo_valid_i = 1; amo_addr_i = 64'h1000_0020;
    step();
    ac_valid_i = 0;
    step();
    chk("amo_other_line", 64'(last_valid), 64'd1);
    drain();

    // Presented head stays valid and stable when flushing rises.
    idle_inputs();
    ac_valid_i = 1; ac_addr_i = 64'h2222_0030; ac_snoop_i = 4'hD; ac_prot_i = 3'h5;
    step();
    ac_valid_i = 0;
    step();
    chk("sticky_pres", 64'(last_valid), 64'd1);
    flushing_i = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sticky_valid", 64'(last_valid), 64'd1);
      chk("sticky_addr", last_addr, 64'h2222_0030);
    end
    out_ready_i = 1;
    step();
    chk("sticky_hs", 64'(last_valid), 64'd1);
    step();
    chk("sticky_empty", 64'(last_valid), 64'd0);
    drain();

    // Watchdog: one pulse in the 8th blocked cycle.
    idle_inputs();
    flushing_i = 1;
    ac_valid_i = 1; ac_addr_i = 64'h3000_0000;
    step();
    ac_valid_i = 0;
    pulses = 0; pulse_at = -1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (last_stall) begin
        pulses++;
        pulse_at = j;
      end
    end
    chk("wd_pulses", 64'(pulses), 64'd1);
    chk("wd_cycle", 64'(pulse_at), 64'(LIMIT));
    drain();

    // Reset with three entries and a presented head.
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ac_valid_i = 1; ac_addr_i = 64'h4000_0000 + 64'(i << 4);
      step();
    end
    ac_valid_i = 0;
    step();
    chk("pre_rst_valid", 64'(last_valid), 64'd1);
    #2;
    rst_ni = 0;
    #1;
    chk("midrst_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_count", 64'(count_o), 64'd0);
    chk("midrst_ready", 64'(ac_ready_o), 64'd1);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;
    ac_valid_i = 1; ac_addr_i = 64'h5000_0070; ac_snoop_i = 4'hE; out_ready_i = 1;
    step();
    chk("postrst_n", 64'(last_valid), 64'd0);
    ac_valid_i = 0;
    step();
    chk("postrst_n1_valid", 64'(last_valid), 64'd1);
    chk("postrst_n1_addr", last_addr, 64'h5000_0070);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snoop_ac_queue.md
# snoop_ac_queue

Ingress stage for ACE snoop requests (AC channel) in the std data-cache subsystem. It sits between the interconnect's AC channel and the snoop cache controller. It buffers up to DEPTH snoop requests in a FIFO and presents the head request downstream with AXI-stable valid/ready semantics. It also holds back the head request while the miss handler is flushing or an AMO targets the same cache line. A stall watchdog flags heads blocked for too long.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2.
- LINE_OFFSET, 4, byte-offset bits of a cache line (128-bit line); line address = addr[63:LINE_OFFSET].
- STALL_LIMIT, 255, blocked-head cycles before stall_o pulses; 1..255.
- Clock and reset: clk_i and rst_ni; rst_ni is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- ac_valid_i  in  1  upstream snoop request valid.
- ac_ready_o  out  1  upstream ready.
- ac_addr_i  in  64  snoop address.
- ac_snoop_i  in  4  snoop type (ACSNOOP).
- ac_prot_i  in  3  protection bits.
- out_valid_o  out  1  head request valid to the snoop cache controller.
- out_ready_i  in  1  controller accepts the head request.
- out_addr_o  out  64  head address.
- out_snoop_o  out  4  head snoop type.
- out_prot_o  out  3  head protection bits.
- flushing_i  in  1  miss handler is flushing.
- amo_valid_i  in  1  AMO in progress.
- amo_addr_i  in  64  AMO address.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- stall_o  out  1  one-cycle pulse when the head has been blocked STALL_LIMIT consecutive cycles.

## Operation
- FIFO with write pointer wptr_q, read pointer rptr_q (each $clog2(DEPTH) bits, wrap modulo DEPTH) and cnt_q (0..DEPTH).
- Enqueue:
  - ac_ready_o = (cnt_q != DEPTH). This is combinational from registers only; there is no path from out_ready_i.
  - On ac_valid_i && ac_ready_o, write {addr, snoop, prot} at wptr_q and increment wptr_q.
- Head outputs out_addr_o, out_snoop_o and out_prot_o always show entry rptr_q. When the FIFO is empty they are don't-care, and the bench must not check them.
- block = flushing_i || (amo_valid_i && amo_addr_i[63:LINE_OFFSET] == head addr[63:LINE_OFFSET]).
- Sticky presentation flag pres_q:
  - out_valid_o = (cnt_q != 0) && (pres_q || !block).
  - pres_q is set when out_valid_o && !out_ready_i.
  - pres_q is cleared on handshake.
  - Once asserted, out_valid_o stays high with stable payload until out_ready_i, whatever block does.
- Dequeue: on out_valid_o && out_ready_i, increment rptr_q and clear pres_q.
- Simultaneous enqueue and dequeue: cnt_q is unchanged and both pointers advance. When full, enqueue is refused even if a dequeue happens in the same cycle.
- Watchdog counter stall_cnt_q (8 bits):
  - Increments each cycle with cnt_q != 0 && !out_valid_o.
  - Resets to 0 otherwise.
  - stall_o = 1 in the cycle stall_cnt_q reaches STALL_LIMIT. The counter then saturates and stall_o does not repeat until the counter resets.
- Requests are delivered in arrival order. Snoop type is not interpreted; unknown types pass through unchanged.

## Timing
- Reset values: ac_ready_o=1, out_valid_o=0, count_o=0, stall_o=0; pointers, pres_q and stall_cnt_q are 0.
- Latency:
  - A request accepted at edge N is visible at out_valid_o after edge N, i.e. cycle N+1, if not blocked.
  - There is no same-cycle bypass.
- Throughput is one request per cycle in steady state when out_ready_i is held high.
- Block is sampled only while pres_q=0. AMO or flush assertion after presentation has no effect on the presented request.
- count_o = cnt_q, registered.
- Reset mid-operation: all entries are discarded and the pres_q/watchdog state is cleared asynchronously. The first request after reset release behaves as from empty.

## Test plan
- Single request:
  - Stimulus: addr 0x8000_0040, snoop 0x8 at edge 0, with out_ready_i=1.
  - Required: out_valid_o=1 in cycle 1 with the identical payload; count_o goes 1 then 0; ac_ready_o stays 1.
- Fill and backpressure (DEPTH=4, out_ready_i=0):
  - Stimulus: push 5 back-to-back requests.
  - Required: ac_ready_o drops after the 4th; count_o=4; the 5th is accepted only after one dequeue. Drain order is A,B,C,D,E.
- AMO conflict:
  - Stimulus: head addr 0x1000_0010, amo_addr 0x1000_0018 held 10 cycles.
  - Required: out_valid_o=0 for those 10 cycles. It is 1 in the cycle amo_valid_i drops. A different-line AMO (0x1000_0020) causes no block.
- Sticky valid:
  - Stimulus: the head is presented with out_ready_i=0, then flushing_i rises.
  - Required: out_valid_o and payload stay stable until out_ready_i=1.
- Watchdog (STALL_LIMIT=8):
  - Stimulus: hold flushing_i 20 cycles with one queued entry.
  - Required: exactly one stall_o pulse, in the 8th blocked cycle.
- Reset mid-operation:
  - Stimulus: assert rst_ni=0 with 3 entries and a presented head.
  - Required: out_valid_o=0 and count_o=0 immediately, ac_ready_o=1. After release, a new request emerges in its cycle N+1.
